// File: rtl/cpu_shift_pkg.sv
// Shared definitions for the shifter operand-fetch path:
// shift op codes, fetch FSM states and operand-2 field positions.
package cpu_shift_pkg;

  localparam logic [1:0] SHIFT_LSL = 2'd0;
  localparam logic [1:0] SHIFT_LSR = 2'd1;
  localparam logic [1:0] SHIFT_ASR = 2'd2;
  localparam logic [1:0] SHIFT_ROR = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ_RM = 2'd1,
    READ_RS = 2'd2,
    OUT     = 2'd3
  } state_t;

  localparam int I_BIT        = 25;
  localparam int REGSHIFT_BIT = 4;
  localparam int IMM8_LSB     = 0;
  localparam int ROT_LSB      = 8;
  localparam int RM_LSB       = 0;
  localparam int RS_LSB       = 8;
  localparam int OP_LSB       = 5;
  localparam int IMM5_LSB     = 7;

endpackage

// File: rtl/op2_field_decode.sv
// Combinational split of a data-processing instruction
// into its operand-2 fields.
module op2_field_decode
  import cpu_shift_pkg::*;
(
  input  logic [31:0] instr,
  output logic        imm,
  output logic        regshift,
  output logic [3:0]  rm,
  output logic [3:0]  rs,
  output logic [1:0]  op,
  output logic [4:0]  imm5,
  output logic [7:0]  imm8,
  output logic [3:0]  rot
);

  logic unused_bits;

  assign imm      = instr[I_BIT];
  assign regshift = !instr[I_BIT] && instr[REGSHIFT_BIT];
  assign rm       = instr[RM_LSB +: 4];
  assign rs       = instr[RS_LSB +: 4];
  assign op       = instr[OP_LSB +: 2];
  assign imm5     = instr[IMM5_LSB +: 5];
  assign imm8     = instr[IMM8_LSB +: 8];
  assign rot      = instr[ROT_LSB +: 4];

  assign unused_bits = ^{instr[31:26], instr[24:12]};

endmodule

// File: rtl/shifter_operand_fetch.sv
// Operand-2 fetch in front of the barrel shifter: reads Rm/Rs
// over one RF port and hands a registered shift bundle downstream.
module shifter_operand_fetch
  import cpu_shift_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_AW     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic                  carry_flag,
  output logic [REG_AW-1:0]     rf_addr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] shift_in,
  output logic [ADDR_WIDTH-1:0] shift_amount,
  output logic [1:0]            shift_op,
  output logic                  shift_carry_in,
  output logic                  rs_zero,
  output logic                  rs_ge32
);

  state_t state, state_nx;

  logic       d_imm;
  logic       d_regshift;
  logic [3:0] d_rm;
  logic [3:0] d_rs;
  logic [1:0] d_op;
  logic [4:0] d_imm5;
  logic [7:0] d_imm8;
  logic [3:0] d_rot;

  logic [REG_AW-1:0] cap_rm;
  logic [REG_AW-1:0] cap_rs;
  logic [1:0]        cap_op;
  logic [4:0]        cap_imm5;
  logic              cap_regshift;

  op2_field_decode u_dec (
    .instr    (instr),
    .imm      (d_imm),
    .regshift (d_regshift),
    .rm       (d_rm),
    .rs       (d_rs),
    .op       (d_op),
    .imm5     (d_imm5),
    .imm8     (d_imm8),
    .rot      (d_rot)
  );

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rf_addr   = '0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nx = d_imm ? OUT : READ_RM;
      end
      READ_RM: begin
        rf_addr  = cap_rm;
        state_nx = cap_regshift ? READ_RS : OUT;
      end
      READ_RS: begin
        rf_addr  = cap_rs;
        state_nx = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_rm         <= '0;
      cap_rs         <= '0;
      cap_op         <= '0;
      cap_imm5       <= '0;
      cap_regshift   <= 1'b0;
      shift_in       <= '0;
      shift_amount   <= '0;
      shift_op       <= '0;
      shift_carry_in <= 1'b0;
      rs_zero        <= 1'b0;
      rs_ge32        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            cap_rm         <= REG_AW'(d_rm);
            cap_rs         <= REG_AW'(d_rs);
            cap_op         <= d_op;
            cap_imm5       <= d_imm5;
            cap_regshift   <= d_regshift;
            shift_carry_in <= carry_flag;
            rs_zero        <= 1'b0;
            rs_ge32        <= 1'b0;
            if (d_imm) begin
              shift_in     <= DATA_WIDTH'(d_imm8);
              shift_op     <= SHIFT_ROR;
              shift_amount <= ADDR_WIDTH'({d_rot, 1'b0});
            end
          end
        end
        READ_RM: begin
          shift_in <= rf_data;
          shift_op <= cap_op;
          if (!cap_regshift)
            shift_amount <= ADDR_WIDTH'(cap_imm5);
        end
        READ_RS: begin
          // Only Rs[7:0] matters; out-of-range distances are flagged
          shift_amount <= rf_data[ADDR_WIDTH-1:0];
          rs_zero      <= (rf_data[7:0] == 8'd0);
          rs_ge32      <= (rf_data[7:5] != 3'd0);
        end
        OUT: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_operand_fetch.sv
// Self-checking bench for shifter_operand_fetch: directed
// vectors, randomized transactions vs a reference model, reset abort.
module tb_shifter_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        carry_flag;
  logic [3:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] shift_in;
  logic [4:0]  shift_amount;
  logic [1:0]  shift_op;
  logic        shift_carry_in;
  logic        rs_zero;
  logic        rs_ge32;

  logic [31:0] rf_mem [16];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] si;
    logic [4:0]  amt;
    logic [1:0]  op;
    logic        z;
    logic        g;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic        c;
    logic [31:0] rmv;
    logic [31:0] rsv;
    int          hold;
    exp_t        e;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  assign rf_data = rf_mem[rf_addr];

  shifter_operand_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .instr          (instr),
    .carry_flag     (carry_flag),
    .rf_addr        (rf_addr),
    .rf_data        (rf_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .shift_in       (shift_in),
    .shift_amount   (shift_amount),
    .shift_op       (shift_op),
    .shift_carry_in (shift_carry_in),
    .rs_zero        (rs_zero),
    .rs_ge32        (rs_ge32)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] bundle();
    return {22'd0, shift_in, shift_amount, shift_op,
            shift_carry_in, rs_zero, rs_ge32};
  endfunction

  function automatic logic [63:0] pack(input exp_t e, input logic c);
    return {22'd0, e.si, e.amt, e.op, c, e.z, e.g};
  endfunction

  function automatic exp_t mk(input logic [31:0] si, input int amt,
                              input int op, input bit z, input bit g,
                              input int lat);
    exp_t e;
    e.si  = si;
    e.amt = amt[4:0];
    e.op  = op[1:0];
    e.z   = z;
    e.g   = g;
    e.lat = lat;
    return e;
  endfunction

  // Operand-2 semantics from the instruction fields and RF contents
  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    int   s;
    e = mk(0, 0, 0, 0, 0, 0);
    if (ins[25]) begin
      e.si  = 32'(ins[7:0]);
      e.op  = 2'd3;
      e.amt = 5'(int'(ins[11:8]) * 2);
      e.lat = 1;
    end else begin
      e.si = rf_mem[ins[3:0]];
      e.op = ins[6:5];
      if (ins[4]) begin
        s     = int'(rf_mem[ins[11:8]] % 256);
        e.amt = 5'(s % 32);
        e.z   = (s == 0);
        e.g   = (s >= 32);
        e.lat = 3;
      end else begin
        e.amt = ins[11:7];
        e.lat = 2;
      end
    end
    return e;
  endfunction

  task automatic run_txn(input logic [31:0] ins, input logic c,
                         input exp_t e, input int hold,
                         input string tag);
    int         n;
    bit         ok;
    logic [3:0] addrs[$];
    logic [3:0] want[$];
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s in_ready", tag), 64'(in_ready), 64'd1);
    instr      = ins;
    carry_flag = c;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 8) begin
      addrs.push_back(rf_addr);
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s latency", tag), 64'(n), 64'(e.lat));
    if (e.lat >= 2) want.push_back(ins[3:0]);
    if (e.lat == 3) want.push_back(ins[11:8]);
    ok = (addrs.size() == want.size());
    if (ok)
      foreach (want[k])
        if (addrs[k] !== want[k]) ok = 1'b0;
    chk($sformatf("%s rf_addr seq", tag), 64'(ok), 64'd1);
    chk($sformatf("%s rf_addr out", tag), 64'(rf_addr), 64'd0);
    chk($sformatf("%s bundle", tag), bundle(), pack(e, c));
    for (int h = 0; h < hold; h++) begin
      instr      = ~ins;
      carry_flag = ~c;
      in_valid   = 1'b1;
      @(negedge clk);
      chk($sformatf("%s hold bundle", tag), bundle(), pack(e, c));
      chk($sformatf("%s hold hs", tag),
          64'({out_valid, in_ready}), 64'd2);
    end
    in_valid   = 1'b0;
    instr      = ins;
    carry_flag = c;
    out_ready  = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("%s drain hs", tag),
        64'({out_valid, in_ready}), 64'd1);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] ins;
    logic        c;

    rst        = 1'b1;
    in_valid   = 1'b0;
    instr      = '0;
    carry_flag = 1'b0;
    out_ready  = 1'b0;
    for (int k = 0; k < 16; k++) rf_mem[k] = '0;

    tbl[0] = '{32'hE3A000FF, 1'b1, 0, 0, 0, mk(32'hFF, 0, 3, 0, 0, 1)};
    tbl[1] = '{32'hE3A004FF, 1'b0, 0, 0, 0, mk(32'hFF, 8, 3, 0, 0, 1)};
    tbl[2] = '{32'hE3A00F81, 1'b1, 0, 0, 0, mk(32'h81, 30, 3, 0, 0, 1)};
    tbl[3] = '{32'hE1A002A2, 1'b0, 32'h80000000, 0, 0,
               mk(32'h80000000, 5, 1, 0, 0, 2)};
    tbl[4] = '{32'hE1A00351, 1'b1, 32'hF0000000, 32'h104, 5,
               mk(32'hF0000000, 4, 2, 0, 0, 3)};
    tbl[5] = '{32'hE1A00351, 1'b0, 32'hF0000000, 32'h100, 0,
               mk(32'hF0000000, 0, 2, 1, 0, 3)};
    tbl[6] = '{32'hE1A00351, 1'b1, 32'hF0000000, 32'h28, 1,
               mk(32'hF0000000, 8, 2, 0, 1, 3)};
    tbl[7] = '{32'hE1A0000F, 1'b1, 32'h12345678, 0, 0,
               mk(32'h12345678, 0, 0, 0, 0, 2)};

    @(negedge clk);
    @(negedge clk);
    chk("reset bundle", bundle(), 64'd0);
    chk("reset hs", 64'({out_valid, in_ready}), 64'd1);
    chk("reset rf_addr", 64'(rf_addr), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (!tbl[i].ins[25]) rf_mem[tbl[i].ins[3:0]] = tbl[i].rmv;
      if (!tbl[i].ins[25] && tbl[i].ins[4])
        rf_mem[tbl[i].ins[11:8]] = tbl[i].rsv;
      run_txn(tbl[i].ins, tbl[i].c, tbl[i].e, tbl[i].hold,
              $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 16; k++) begin
        rf_mem[k] = $urandom;
        if ($urandom_range(0, 3) == 0) rf_mem[k][7:0] = 8'd0;
      end
      ins = $urandom;
      c   = 1'($urandom_range(0, 1));
      e   = model(ins);
      run_txn(ins, c, e, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    rf_mem[1] = 32'hF0000000;
    rf_mem[3] = 32'h28;
    instr      = 32'hE1A00351;
    carry_flag = 1'b1;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort read_rm addr", 64'(rf_addr), 64'd1);
    @(negedge clk);
    chk("abort read_rs addr", 64'(rf_addr), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("abort bundle", bundle(), 64'd0);
    chk("abort hs", 64'({out_valid, in_ready}), 64'd1);
    chk("abort rf_addr", 64'(rf_addr), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort no bundle", 64'(out_valid), 64'd0);
    end
    run_txn(32'hE1A002A2, 1'b0, model(32'hE1A002A2), 0, "post_abort");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
